mips_cpu_regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the MIPS32 core, replacing the fixed 2-read/1-write file. Adds write-to-read bypass, a per-register pending scoreboard for hazard detection between issue and writeback, and a sequential clear engine. Sits between decode/issue (read, reserve) and writeback (write) in the datapath.

---
 rtl/mips_cpu_pkg.sv | 14 +
 rtl/mips_cpu_regfile_sweep.sv | 64 ++++++
 rtl/mips_cpu_regfile_mp.sv | 122 ++++++++++++
 tb/tb_mips_cpu_regfile_mp.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared constants and types for the MIPS32 core register file.
// Parameter defaults of the register file come from here.
package mips_cpu_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_V0     = 2;

    typedef enum logic {
        RF_IDLE,
        RF_SWEEP
    } rf_state_t;

endpackage

// File: rtl/mips_cpu_regfile_sweep.sv
// Clear engine for the register file: walks idx from 1 to DEPTH-1,
// zeroing one register per cycle while busy is high.
module mips_cpu_regfile_sweep
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_idx,
    output rf_state_t         state_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Register 0 is hard-wired to zero, so the sweep starts at 1.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy     = 1'b0;
        sweep_we = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clear_req) begin
                    state_d = RF_SWEEP;
                    idx_d   = ADDR_W'(1);
                end
            end
            RF_SWEEP: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                idx_d    = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign sweep_idx = idx_q;
    assign state_o   = state_q;

endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-read-port register file with write bypass, pending scoreboard
// and a sequential clear engine.
module mips_cpu_regfile_mp
    import mips_cpu_pkg::*;
#(
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int N_RD    = 2,
    parameter int DBG_REG = REG_V0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_pending,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     clear_req,
    output logic                     busy,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] array_q [DEPTH];
    logic [DATA_W-1:0] array_d [DEPTH];
    logic [DEPTH-1:0]  pending_q, pending_d;

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_idx;
    rf_state_t         sweep_state;
    logic              in_sweep;
    logic              wr_ok;
    logic              rsv_ok;

    mips_cpu_regfile_sweep #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .sweep_we  (sweep_we),
        .sweep_idx (sweep_idx),
        .state_o   (sweep_state)
    );

    // All strobes are single-cycle with no backpressure; the only flow
    // control is busy, during which writes, reserves and clear_req drop.
    assign in_sweep = (sweep_state == RF_SWEEP);
    assign wr_ok    = wr_en  && (wr_addr  != '0) && !in_sweep;
    assign rsv_ok   = rsv_en && (rsv_addr != '0) && !in_sweep;

    // Reserve is applied after the write so a same-cycle pair leaves pending set.
    always_comb begin
        array_d   = array_q;
        pending_d = pending_q;
        if (sweep_we) begin
            array_d[sweep_idx]   = '0;
            pending_d[sweep_idx] = 1'b0;
        end else begin
            if (wr_ok) begin
                array_d[wr_addr]   = wr_data;
                pending_d[wr_addr] = 1'b0;
            end
            if (rsv_ok) begin
                pending_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            array_q   <= '{default: '0};
            pending_q <= '0;
        end else begin
            array_q   <= array_d;
            pending_q <= pending_d;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              bypass;
        logic [DATA_W-1:0] data_d, data_q;
        logic              pend_d, pend_q;

        assign ra     = rd_addr[p*ADDR_W +: ADDR_W];
        assign bypass = wr_ok && (wr_addr == ra);

        // Pending flag reflects this cycle's reserve/write so issue sees it at once.
        always_comb begin
            data_d = '0;
            pend_d = 1'b0;
            if (!in_sweep) begin
                data_d = bypass ? wr_data : array_q[ra];
                pend_d = pending_d[ra];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else begin
                data_q <= data_d;
                pend_q <= pend_d;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_q;
        assign rd_pending[p]               = pend_q;
    end

    // Debug tap has no bypass: it shows the stored value only.
    assign dbg_data = array_q[DBG_IDX];

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Bench for mips_cpu_regfile_mp: directed tests plus random traffic checked
// every cycle against a behavioural model; a second 4-port 64-bit instance.
module tb_mips_cpu_regfile_mp;
  import mips_cpu_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        clear_req;
  logic        busy;
  logic [31:0] dbg_data;

  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_pending;
  logic         b_rsv_en;
  logic [3:0]   b_rsv_addr;
  logic         b_clear_req;
  logic         b_busy;
  logic [63:0]  b_dbg_data;

  mips_cpu_regfile_mp dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .clear_req  (clear_req),
    .busy       (busy),
    .dbg_data   (dbg_data)
  );

  mips_cpu_regfile_mp #(
    .DATA_W (64),
    .ADDR_W (4),
    .N_RD   (4)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (b_wr_en),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .rd_pending (b_rd_pending),
    .rsv_en     (b_rsv_en),
    .rsv_addr   (b_rsv_addr),
    .clear_req  (b_clear_req),
    .busy       (b_busy),
    .dbg_data   (b_dbg_data)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] m_arr [32];
  bit          m_pend [32];
  int          m_sweep_left = 0;
  int          m_sweep_idx  = 0;
  bit          m_live = 0;
  logic [31:0] exp_rd [2];
  bit          exp_pend [2];
  bit          exp_busy;
  logic [31:0] exp_dbg;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_arr[i]  = '0;
        m_pend[i] = 0;
      end
      m_sweep_left = 0;
      m_sweep_idx  = 0;
      for (int p = 0; p < 2; p++) begin
        exp_rd[p]   = '0;
        exp_pend[p] = 0;
      end
      m_live = 1;
    end else if (m_live) begin
      if (m_sweep_left > 0) begin
        m_arr[m_sweep_idx]  = '0;
        m_pend[m_sweep_idx] = 0;
        m_sweep_idx++;
        m_sweep_left--;
        for (int p = 0; p < 2; p++) begin
          exp_rd[p]   = '0;
          exp_pend[p] = 0;
        end
      end else begin
        if (wr_en && wr_addr != 0) begin
          m_arr[wr_addr]  = wr_data;
          m_pend[wr_addr] = 0;
        end
        if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
        // A read observes the register as it stands after this cycle's update.
        for (int p = 0; p < 2; p++) begin
          exp_rd[p]   = m_arr[rd_addr[p*5 +: 5]];
          exp_pend[p] = m_pend[rd_addr[p*5 +: 5]];
        end
        if (clear_req) begin
          m_sweep_left = 31;
          m_sweep_idx  = 1;
        end
      end
    end
    exp_busy = (m_sweep_left > 0);
    exp_dbg  = m_arr[2];
    if (m_live) begin
      #1;
      for (int p = 0; p < 2; p++) begin
        check($sformatf("m_rd_data%0d", p), 64'(rd_data[p*32 +: 32]), 64'(exp_rd[p]));
        check($sformatf("m_rd_pend%0d", p), 64'(rd_pending[p]), 64'(exp_pend[p]));
      end
      check("m_busy", 64'(busy), 64'(exp_busy));
      check("m_dbg", 64'(dbg_data), 64'(exp_dbg));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rsv_en    = 1'b0;
    rsv_addr  = '0;
    clear_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int cnt;

  initial begin
    reset = 1'b1;
    idle_inputs();
    rd_addr     = '0;
    b_wr_en     = 1'b0;
    b_wr_addr   = '0;
    b_wr_data   = '0;
    b_rd_addr   = '0;
    b_rsv_en    = 1'b0;
    b_rsv_addr  = '0;
    b_clear_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state across every address on both ports.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      tick();
      if (a > 0) begin
        check("rst_rd", rd_data, 64'h0);
        check("rst_pend", 64'(rd_pending), 64'h0);
      end
    end
    check("rst_dbg", 64'(dbg_data), 64'h0);

    // Same-cycle write/read bypass, and r0 stays zero.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    tick();
    check("byp_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    tick();
    check("r0_byp", 64'(rd_data[31:0]), 64'h0);
    idle_inputs();
    tick();
    check("r0_read", 64'(rd_data[31:0]), 64'h0);

    // Reserve / write interplay on r7.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle_inputs(); rd_addr = {5'd0, 5'd7};
    tick();
    check("rsv_pend", 64'(rd_pending[0]), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    tick();
    check("wr7_data", 64'(rd_data[31:0]), 64'h55);
    check("wr7_pend", 64'(rd_pending[0]), 64'h0);
    idle_inputs();
    tick();
    check("rd7_pend", 64'(rd_pending[0]), 64'h0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    check("setwin_pend", 64'(rd_pending[0]), 64'h1);
    check("setwin_data", 64'(rd_data[31:0]), 64'h66);
    idle_inputs();

    // Debug tap follows r2 one cycle after the write edge.
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hCAFEF00D;
    tick();
    check("dbg_v0", 64'(dbg_data), 64'hCAFEF00D);
    idle_inputs();

    // Fill r1..r31, then sweep; writes and a second clear_req during it are ignored.
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'hA500_0000 + 32'(a * 32'h111);
      rd_addr = {5'(a), 5'(a)};
      tick();
    end
    idle_inputs();
    clear_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) cnt++;
      clear_req = (i == 14);
      wr_en   = (i < 25);
      wr_addr = 5'($urandom_range(1, 31));
      wr_data = $urandom;
      rsv_en  = (i < 25);
      rsv_addr = 5'($urandom_range(1, 31));
    end
    check("sweep_len", 64'(cnt), 64'd31);
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      tick();
      check("post_sweep_rd", rd_data, 64'h0);
      check("post_sweep_pend", 64'(rd_pending), 64'h0);
    end

    // Reset partway through a sweep, then restart from idx 1.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999;
    tick();
    idle_inputs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    clear_req = 1'b1;
    tick();
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_state", 64'(dut.u_sweep.state_o), 64'(RF_IDLE));
    reset = 1'b0;
    clear_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) check("restart_idx", 64'(dut.u_sweep.sweep_idx), 64'd1);
      if (busy) cnt++;
      clear_req = 1'b0;
    end
    check("restart_len", 64'(cnt), 64'd31);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      rsv_en    = ($urandom_range(0, 2) == 0);
      rsv_addr  = 5'($urandom);
      rd_addr   = ($urandom_range(0, 3) == 0) ? {wr_addr, wr_addr} : 10'($urandom);
      clear_req = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 35; i++) tick();

    // Wide instance: 4 ports, 64-bit data, 16 registers.
    b_wr_en = 1'b1; b_wr_addr = 4'd9; b_wr_data = 64'h0123_4567_89AB_CDEF;
    b_rd_addr = {4'd9, 4'd9, 4'd9, 4'd9};
    tick();
    for (int p = 0; p < 4; p++)
      check($sformatf("b_byp%0d", p), b_rd_data[p*64 +: 64], 64'h0123_4567_89AB_CDEF);
    b_wr_addr = 4'd15; b_wr_data = 64'hFEDC_BA98_7654_3210;
    b_rd_addr = {4'd3, 4'd0, 4'd9, 4'd15};
    tick();
    check("b_byp15", b_rd_data[63:0], 64'hFEDC_BA98_7654_3210);
    check("b_old9", b_rd_data[127:64], 64'h0123_4567_89AB_CDEF);
    check("b_r0", b_rd_data[191:128], 64'h0);
    check("b_r3", b_rd_data[255:192], 64'h0);
    b_wr_en = 1'b0;
    b_rd_addr = {4'd15, 4'd1, 4'd1, 4'd1};
    tick();
    check("b_rd15", b_rd_data[255:192], 64'hFEDC_BA98_7654_3210);
    check("b_pend", 64'(b_rd_pending), 64'h0);
    check("b_busy", 64'(b_busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
